hd_transfer_controller: RTL and testbench
=========================================

Name: hd_transfer_controller

Overview:
- Block-transfer sequencer between the hard drive (track/sector addressed, 32-bit words) and main data memory.
- On a start command it copies LENGTH consecutive words in one of two directions:
  - HD->memory: program/data load.
  - memory->HD: store/swap-out.
- Owns the hard drive's track, sector and write-flag inputs for the whole transfer.
- Reports busy, a one-cycle done pulse, and an error flag for address overflow.

Parameters:
- DATA_W, 32, word width of hard drive and memory.
- TRACK_W, 7, track address width.
- SECTOR_W, 14, sector address width.
- SECTORS_PER_TRACK, 10, sectors used per track; sector wraps to 0 and track increments after sector SECTORS_PER_TRACK-1.
- NUM_TRACKS, 8, valid tracks 0..NUM_TRACKS-1.
- MEM_ADDR_W, 10, memory word address width.
- LEN_W, 10, transfer length width.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  command strobe; sampled only in IDLE.
- direction  in  1  0 = HD->memory, 1 = memory->HD.
- start_track  in  TRACK_W  first track.
- start_sector  in  SECTOR_W  first sector.
- mem_base  in  MEM_ADDR_W  first memory address.
- length  in  LEN_W  word count.
- track  out  TRACK_W  to hard drive.
- sector  out  SECTOR_W  to hard drive.
- data_write  out  DATA_W  to hard drive.
- flag_write_hd  out  1  hard drive write enable.
- output_hard_drive  in  DATA_W  hard drive read data, combinational from track/sector.
- mem_addr  out  MEM_ADDR_W  memory address.
- mem_data_write  out  DATA_W  memory write data.
- mem_write_enable  out  1  memory write enable.
- mem_data_read  in  DATA_W  memory read data, valid one cycle after mem_addr is presented.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at end of transfer.
- error  out  1  sticky overflow flag; cleared by the next accepted start or by reset.

Behaviour:
- Reset values:
  - State IDLE.
  - track, sector, mem_addr, data_write, mem_data_write = 0.
  - flag_write_hd, mem_write_enable, busy, done, error = 0.
  - Remaining count = 0.
- Reset mid-transfer aborts immediately. No further write strobes; a partially written block is left as-is.
- States: IDLE, LOAD, STORE_RD, STORE_WR, FINISH.
- IDLE + start:
  - Latch start_track, start_sector, mem_base and length; clear error.
  - Next state: length==0 -> FINISH; direction==0 -> LOAD; direction==1 -> STORE_RD.
  - A start_track >= NUM_TRACKS or start_sector >= SECTORS_PER_TRACK sets error and goes to FINISH with no writes.
- LOAD, one word per cycle:
  - mem_write_enable=1, mem_data_write=output_hard_drive (combinational), at the current mem_addr and track/sector.
  - On the clock edge: advance the address and decrement the count.
  - Last word (count==1) -> FINISH.
  - Transfer of L words takes L LOAD cycles.
- STORE_RD: present mem_addr; no writes; -> STORE_WR.
- STORE_WR, two cycles per word in total:
  - flag_write_hd=1, data_write=mem_data_read, at the current track/sector.
  - On the clock edge: advance the address and decrement the count.
  - count==1 -> FINISH, else -> STORE_RD.
- Address advance:
  - mem_addr+1, wrapping modulo 2^MEM_ADDR_W.
  - sector+1; if sector==SECTORS_PER_TRACK-1 then sector=0 and track+1.
  - If track would reach NUM_TRACKS with words remaining: set error and go to FINISH. No write occurs to the out-of-range track.
- FINISH: done=1 for exactly one cycle, busy=0 in this cycle, -> IDLE.
- busy is 1 in LOAD, STORE_RD and STORE_WR only.
- start while not IDLE is ignored and has no side effects.
- In IDLE and FINISH:
  - track/sector hold their last value.
  - flag_write_hd and mem_write_enable are 0.
- flag_write_hd and mem_write_enable are never high in the same cycle.

Test Plan:
- Reset, then start, direction=0, start_track=0, start_sector=0, mem_base=16, length=5, with the HD preloaded with 1..5:
  - Memory addresses 16..20 receive 1..5 on five consecutive cycles.
  - done pulses the cycle after the 5th write; busy is high for exactly 5 cycles.
- direction=1, mem_base=0 holding A0..A2, start_track=1, start_sector=8, length=3:
  - HD[1][8]=A0, HD[1][9]=A1, HD[2][0]=A2 (sector wrap, track increment).
  - Writes fall 2 cycles apart; done is asserted 7 cycles after start.
- length=0:
  - done pulses the cycle after start; no write strobes; busy stays 0.
- start_track=7, start_sector=9, length=3, direction=0:
  - Exactly one write (from HD[7][9]), then error=1 and done.
  - A new valid start clears error.
- Start during a busy LOAD with different parameters:
  - The original transfer completes unchanged; only one done pulse.
- Reset asserted on the 3rd LOAD cycle of a length-8 load:
  - Next cycle: busy=0, no write strobes, outputs at reset values.
  - A subsequent start works normally.

Source files
------------

// File: rtl/hd_transfer_controller.sv
// Block-transfer sequencer between the track/sector addressed hard drive and
// word-addressed main memory, in either direction, with address-overflow detection.
module hd_transfer_controller #(
    parameter int DATA_W            = 32,
    parameter int TRACK_W           = 7,
    parameter int SECTOR_W          = 14,
    parameter int SECTORS_PER_TRACK = 10,
    parameter int NUM_TRACKS        = 8,
    parameter int MEM_ADDR_W        = 10,
    parameter int LEN_W             = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  direction,
    input  logic [TRACK_W-1:0]    start_track,
    input  logic [SECTOR_W-1:0]   start_sector,
    input  logic [MEM_ADDR_W-1:0] mem_base,
    input  logic [LEN_W-1:0]      length,
    output logic [TRACK_W-1:0]    track,
    output logic [SECTOR_W-1:0]   sector,
    output logic [DATA_W-1:0]     data_write,
    output logic                  flag_write_hd,
    input  logic [DATA_W-1:0]     output_hard_drive,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_data_write,
    output logic                  mem_write_enable,
    input  logic [DATA_W-1:0]     mem_data_read,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE_RD,
        STORE_WR,
        FINISH
    } state_t;

    localparam logic [SECTOR_W-1:0] LAST_SECTOR = SECTOR_W'(SECTORS_PER_TRACK - 1);
    localparam logic [TRACK_W-1:0]  LAST_TRACK  = TRACK_W'(NUM_TRACKS - 1);
    localparam logic [LEN_W-1:0]    ONE_WORD    = LEN_W'(1);

    state_t                  state, state_n;
    logic [TRACK_W-1:0]      track_n;
    logic [SECTOR_W-1:0]     sector_n;
    logic [MEM_ADDR_W-1:0]   mem_addr_n;
    logic [LEN_W-1:0]        count, count_n;
    logic                    error_n;

    logic                    step;
    logic                    last_sector;
    logic                    overflow;
    logic                    start_valid;
    logic [SECTOR_W-1:0]     sector_inc;
    logic [TRACK_W-1:0]      track_inc;

    assign last_sector = (sector == LAST_SECTOR);
    assign sector_inc  = last_sector ? '0 : sector + 1'b1;
    assign track_inc   = last_sector ? track + 1'b1 : track;
    // Stepping off the last sector of the last track is only fatal while words remain.
    assign overflow    = last_sector && (track == LAST_TRACK) && (count != ONE_WORD);
    assign start_valid = (32'(start_track) < 32'(NUM_TRACKS)) &&
                         (32'(start_sector) < 32'(SECTORS_PER_TRACK));

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_n          = state;
        track_n          = track;
        sector_n         = sector;
        mem_addr_n       = mem_addr;
        count_n          = count;
        error_n          = error;
        step             = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        flag_write_hd    = 1'b0;
        mem_write_enable = 1'b0;
        data_write       = '0;
        mem_data_write   = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    track_n    = start_track;
                    sector_n   = start_sector;
                    mem_addr_n = mem_base;
                    count_n    = length;
                    error_n    = !start_valid;
                    if (!start_valid || length == '0) begin
                        state_n = FINISH;
                    end else begin
                        state_n = direction ? STORE_RD : LOAD;
                    end
                end
            end
            LOAD: begin
                busy             = 1'b1;
                mem_write_enable = 1'b1;
                mem_data_write   = output_hard_drive;
                step             = 1'b1;
            end
            STORE_RD: begin
                busy    = 1'b1;
                state_n = STORE_WR;
            end
            STORE_WR: begin
                busy          = 1'b1;
                flag_write_hd = 1'b1;
                data_write    = mem_data_read;
                step          = 1'b1;
            end
            FINISH: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (step) begin
            mem_addr_n = mem_addr + 1'b1;
            count_n    = count - 1'b1;
            if (count == ONE_WORD) begin
                state_n = FINISH;
            end else if (overflow) begin
                error_n = 1'b1;
                state_n = FINISH;
            end else begin
                state_n = (state == LOAD) ? LOAD : STORE_RD;
            end
            if (!overflow) begin
                track_n  = track_inc;
                sector_n = sector_inc;
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            track    <= '0;
            sector   <= '0;
            mem_addr <= '0;
            count    <= '0;
            error    <= 1'b0;
        end else begin
            state    <= state_n;
            track    <= track_n;
            sector   <= sector_n;
            mem_addr <= mem_addr_n;
            count    <= count_n;
            error    <= error_n;
        end
    end

endmodule

// File: tb/tb_hd_transfer_controller.sv
// Self-checking bench for hd_transfer_controller: directed scenarios plus
// randomized transfers checked cycle by cycle against a word-list reference model.
module tb_hd_transfer_controller;

    localparam int DATA_W = 32;
    localparam int TRACK_W = 7;
    localparam int SECTOR_W = 14;
    localparam int SPT = 10;
    localparam int NTRK = 8;
    localparam int MEM_ADDR_W = 10;
    localparam int LEN_W = 10;
    localparam int MEM_WORDS = 1 << MEM_ADDR_W;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  direction;
    logic [TRACK_W-1:0]    start_track;
    logic [SECTOR_W-1:0]   start_sector;
    logic [MEM_ADDR_W-1:0] mem_base;
    logic [LEN_W-1:0]      length;
    logic [TRACK_W-1:0]    track;
    logic [SECTOR_W-1:0]   sector;
    logic [DATA_W-1:0]     data_write;
    logic                  flag_write_hd;
    logic [DATA_W-1:0]     output_hard_drive;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_data_write;
    logic                  mem_write_enable;
    logic [DATA_W-1:0]     mem_data_read;
    logic                  busy;
    logic                  done;
    logic                  error;

    hd_transfer_controller dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .direction         (direction),
        .start_track       (start_track),
        .start_sector      (start_sector),
        .mem_base          (mem_base),
        .length            (length),
        .track             (track),
        .sector            (sector),
        .data_write        (data_write),
        .flag_write_hd     (flag_write_hd),
        .output_hard_drive (output_hard_drive),
        .mem_addr          (mem_addr),
        .mem_data_write    (mem_data_write),
        .mem_write_enable  (mem_write_enable),
        .mem_data_read     (mem_data_read),
        .busy              (busy),
        .done              (done),
        .error             (error)
    );

    always #5 clock = ~clock;

    // Environment: hard drive with combinational read, memory with one-cycle read latency.
    logic [DATA_W-1:0] hd  [0:127][0:15];
    logic [DATA_W-1:0] mem [0:MEM_WORDS-1];
    logic [DATA_W-1:0] ref_hd  [0:127][0:15];
    logic [DATA_W-1:0] ref_mem [0:MEM_WORDS-1];

    always_comb begin
        output_hard_drive = '0;
        if (sector < 16) output_hard_drive = hd[track][sector[3:0]];
    end

    always @(posedge clock) begin
        mem_data_read <= mem[mem_addr];
        if (mem_write_enable) mem[mem_addr] <= mem_data_write;
        if (flag_write_hd && sector < 16) hd[track][sector[3:0]] <= data_write;
    end

    int vectors = 0;
    int miscompares = 0;

    // Expected transfer: list of write events (cycle after the start edge, location, data).
    int                e_cyc  [$];
    int                e_addr [$];
    int                e_t    [$];
    int                e_s    [$];
    logic [DATA_W-1:0] e_data [$];
    int                e_done;
    bit                e_err;

    task automatic model_transfer(input bit dir, input int t, input int s, input int base, input int len);
        int addr;
        logic [DATA_W-1:0] d;
        e_cyc.delete(); e_addr.delete(); e_t.delete(); e_s.delete(); e_data.delete();
        e_err  = 0;
        e_done = 1;
        if (t >= NTRK || s >= SPT) begin
            e_err = 1;
            return;
        end
        addr = base;
        for (int i = 0; i < len; i++) begin
            int cyc;
            cyc = dir ? 2 * i + 2 : i + 1;
            d   = dir ? ref_mem[addr] : ref_hd[t][s];
            if (dir) ref_hd[t][s] = d;
            else     ref_mem[addr] = d;
            e_cyc.push_back(cyc); e_addr.push_back(addr);
            e_t.push_back(t); e_s.push_back(s); e_data.push_back(d);
            e_done = cyc + 1;
            if (i == len - 1) break;
            addr = (addr + 1) % MEM_WORDS;
            s = s + 1;
            if (s == SPT) begin
                s = 0;
                t = t + 1;
                if (t == NTRK) begin
                    e_err = 1;
                    break;
                end
            end
        end
    endtask

    task automatic check_idle(input string name, input bit exp_err);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_write_enable !== 1'b0 ||
            flag_write_hd !== 1'b0 || error !== exp_err) begin
            miscompares++;
            $display("FAIL %s idle: busy=%b done=%b mwe=%b hwe=%b err=%b, want 0 0 0 0 %b",
                     name, busy, done, mem_write_enable, flag_write_hd, error, exp_err);
        end
    endtask

    task automatic check_memories(input string name);
        int bad_m, bad_h;
        bad_m = -1; bad_h = -1;
        for (int a = 0; a < MEM_WORDS; a++)
            if (bad_m < 0 && mem[a] !== ref_mem[a]) bad_m = a;
        for (int t = 0; t < 128; t++)
            for (int s = 0; s < 16; s++)
                if (bad_h < 0 && hd[t][s] !== ref_hd[t][s]) bad_h = t * 16 + s;
        vectors++;
        if (bad_m >= 0) begin
            miscompares++;
            $display("FAIL %s mem[%0d]: got %h, want %h", name, bad_m, mem[bad_m], ref_mem[bad_m]);
        end
        vectors++;
        if (bad_h >= 0) begin
            miscompares++;
            $display("FAIL %s hd[%0d][%0d]: got %h, want %h", name, bad_h / 16, bad_h % 16,
                     hd[bad_h / 16][bad_h % 16], ref_hd[bad_h / 16][bad_h % 16]);
        end
    endtask

    // Issue one start and check every cycle until the expected done (or until abort_at).
    task automatic run_transfer(input string name, input bit dir, input int t, input int s,
                                input int base, input int len, input bit poke, input int abort_at);
        int cycle, k;
        model_transfer(dir, t, s, base, (abort_at > 0) ? abort_at : len);
        start        = 1'b1;
        direction    = dir;
        start_track  = TRACK_W'(t);
        start_sector = SECTOR_W'(s);
        mem_base     = MEM_ADDR_W'(base);
        length       = LEN_W'(len);
        @(posedge clock); #1;
        start = 1'b0;
        cycle = 1;
        k = 0;
        while (1) begin
            bit is_wr;
            if (poke && cycle == 2 && e_done > 3) begin
                start        = 1'b1;
                direction    = ~dir;
                start_track  = TRACK_W'($urandom_range(0, NTRK - 1));
                start_sector = SECTOR_W'($urandom_range(0, SPT - 1));
                mem_base     = MEM_ADDR_W'($urandom);
                length       = LEN_W'($urandom_range(1, 20));
            end else begin
                start = 1'b0;
            end
            #0;
            is_wr = (k < e_cyc.size()) && (e_cyc[k] == cycle);
            vectors++;
            if (mem_write_enable !== (is_wr && !dir) || flag_write_hd !== (is_wr && dir)) begin
                miscompares++;
                $display("FAIL %s strobes c%0d: mwe=%b hwe=%b, want %b %b", name, cycle,
                         mem_write_enable, flag_write_hd, is_wr && !dir, is_wr && dir);
            end
            vectors++;
            if (busy !== (cycle < e_done) || done !== (cycle == e_done) ||
                error !== (e_err && cycle >= e_done)) begin
                miscompares++;
                $display("FAIL %s status c%0d: busy=%b done=%b err=%b, want %b %b %b", name, cycle,
                         busy, done, error, cycle < e_done, cycle == e_done, e_err && cycle >= e_done);
            end
            if (is_wr) begin
                vectors++;
                if (!dir && (mem_addr !== MEM_ADDR_W'(e_addr[k]) || mem_data_write !== e_data[k])) begin
                    miscompares++;
                    $display("FAIL %s load c%0d: addr=%0d data=%h, want %0d %h", name, cycle,
                             mem_addr, mem_data_write, e_addr[k], e_data[k]);
                end
                if (dir && (track !== TRACK_W'(e_t[k]) || sector !== SECTOR_W'(e_s[k]) ||
                            data_write !== e_data[k])) begin
                    miscompares++;
                    $display("FAIL %s store c%0d: t=%0d s=%0d data=%h, want %0d %0d %h", name, cycle,
                             track, sector, data_write, e_t[k], e_s[k], e_data[k]);
                end
                k++;
            end
            if (abort_at > 0 && cycle == abort_at) begin
                reset = 1'b1;
                @(posedge clock); #1;
                vectors++;
                if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || mem_write_enable !== 1'b0 ||
                    flag_write_hd !== 1'b0 || track !== '0 || sector !== '0 || mem_addr !== '0 ||
                    data_write !== '0 || mem_data_write !== '0) begin
                    miscompares++;
                    $display("FAIL %s abort: busy=%b done=%b err=%b mwe=%b hwe=%b t=%0d s=%0d a=%0d",
                             name, busy, done, error, mem_write_enable, flag_write_hd, track, sector, mem_addr);
                end
                reset = 1'b0;
                @(posedge clock); #1;
                check_idle({name, "_post_abort"}, 1'b0);
                check_memories(name);
                return;
            end
            if (cycle >= e_done) break;
            @(posedge clock); #1;
            cycle++;
        end
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            check_idle(name, e_err);
        end
        check_memories(name);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        direction = 1'b0;
        start_track = '0; start_sector = '0; mem_base = '0; length = '0;
        repeat (3) @(posedge clock);
        #1;
        vectors++;
        if (track !== '0 || sector !== '0 || mem_addr !== '0 || data_write !== '0 ||
            mem_data_write !== '0 || flag_write_hd !== 1'b0 || mem_write_enable !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: t=%0d s=%0d a=%0d busy=%b done=%b err=%b, want all 0",
                     track, sector, mem_addr, busy, done, error);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        check_idle("reset_idle", 1'b0);
    endtask

    task automatic test_load_basic();
        for (int i = 0; i < 5; i++) begin
            hd[0][i] = DATA_W'(i + 1);
            ref_hd[0][i] = DATA_W'(i + 1);
        end
        run_transfer("load_basic", 1'b0, 0, 0, 16, 5, 1'b0, 0);
    endtask

    task automatic test_store_wrap();
        for (int i = 0; i < 3; i++) begin
            mem[i] = 32'hA000_0000 + DATA_W'(i);
            ref_mem[i] = 32'hA000_0000 + DATA_W'(i);
        end
        run_transfer("store_wrap", 1'b1, 1, 8, 0, 3, 1'b0, 0);
    endtask

    task automatic test_zero_length();
        run_transfer("zero_len_load", 1'b0, 2, 3, 100, 0, 1'b0, 0);
        run_transfer("zero_len_store", 1'b1, 5, 1, 900, 0, 1'b0, 0);
    endtask

    task automatic test_overflow();
        run_transfer("overflow", 1'b0, 7, 9, 50, 3, 1'b0, 0);
        run_transfer("error_clear", 1'b0, 0, 1, 200, 2, 1'b0, 0);
        run_transfer("bad_track", 1'b1, 9, 0, 10, 4, 1'b0, 0);
        run_transfer("bad_sector", 1'b0, 3, 10, 10, 4, 1'b0, 0);
    endtask

    task automatic test_start_while_busy();
        run_transfer("busy_start_load", 1'b0, 3, 2, 300, 8, 1'b1, 0);
        run_transfer("busy_start_store", 1'b1, 4, 7, 1020, 6, 1'b1, 0);
    endtask

    task automatic test_reset_abort();
        run_transfer("reset_abort", 1'b0, 4, 0, 400, 8, 1'b0, 3);
        run_transfer("after_abort", 1'b0, 4, 0, 400, 8, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int t, s, len;
            t   = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 8) : $urandom_range(0, 7);
            s   = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 12) : $urandom_range(0, 9);
            len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 25);
            run_transfer("random", 1'($urandom), t, s, $urandom_range(0, MEM_WORDS - 1), len,
                         1'($urandom_range(0, 3) == 0), 0);
        end
    endtask

    initial begin
        for (int a = 0; a < MEM_WORDS; a++) begin
            mem[a] = $urandom;
            ref_mem[a] = mem[a];
        end
        for (int t = 0; t < 128; t++)
            for (int s = 0; s < 16; s++) begin
                hd[t][s] = $urandom;
                ref_hd[t][s] = hd[t][s];
            end
        test_reset();
        test_load_basic();
        test_store_wrap();
        test_zero_length();
        test_overflow();
        test_start_while_busy();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
